acumulador_resultado: RTL
=========================

# acumulador_resultado

Downstream consumer of the 4-bit adder stage: it captures the adder's 5-bit `resultado` over a valid/ready handshake and accumulates a programmable number of samples into a wider total. It signals completion with a held `total_valido` and a sticky overflow flag. It turns the combinational adder into a multi-cycle summation datapath for the practice board.

## Interface
Parameters:
- `N_AMOSTRAS`, default 4: samples accumulated per run; legal range 1..255.
- `LARGURA_ACC`, default 8: accumulator width; must be ≥ 5.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `iniciar`  in  1  start pulse; clears total, count and overflow, then begins a run.
- `resultado_valido`  in  1  upstream has a sample on `resultado`.
- `resultado`  in  5  adder output, unsigned, range 0..30.
- `pronto`  out  1  block can accept a sample this cycle.
- `total`  out  LARGURA_ACC  accumulated sum.
- `total_valido`  out  1  run complete; `total` is final.
- `overflow`  out  1  sticky; the sum exceeded 2^LARGURA_ACC−1 during this run.
- `contagem`  out  8  number of samples accepted in the current run.

## Operation
- States: OCIOSO, ACUMULANDO, CONCLUIDO.
- Reset (async, `rst_n`=0): state OCIOSO, `total`=0, `contagem`=0, `overflow`=0, `total_valido`=0, `pronto`=0.
- OCIOSO → ACUMULANDO when `iniciar`=1. The same edge clears `total`, `contagem` and `overflow`.
- ACUMULANDO:
  - `pronto`=1.
  - Transfer occurs when `resultado_valido` && `pronto`.
  - On transfer: `total` ← `total` + zero-extended `resultado`, and `contagem` increments.
- The transfer that makes `contagem` equal `N_AMOSTRAS` moves the state to CONCLUIDO on the same edge.
- CONCLUIDO:
  - `pronto`=0 and `total_valido`=1.
  - Outputs hold until `iniciar`.
  - `iniciar` here moves to ACUMULANDO and clears the run, exactly as from OCIOSO.
- `iniciar` during ACUMULANDO restarts the run: it clears `total`, `contagem` and `overflow`, and any transfer in that same cycle is discarded. `iniciar` has priority.
- `resultado_valido` outside ACUMULANDO is ignored; no state change.
- Overflow:
  - The sum is computed at LARGURA_ACC+1 bits.
  - If the carry-out bit is set, `overflow` goes to 1 and stays 1 until the next `iniciar` or reset.
  - The `total` result depends on the configuration (see Configuration).
- Reset asserted mid-run aborts the run immediately; no partial result is preserved.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- `pronto` is a decode of the state register, so it is valid from the first cycle after `iniciar`.
- A transfer in cycle t updates `total` and `contagem` at the edge ending cycle t.
- `total_valido` rises the cycle after the Nth transfer; `pronto` falls in that same cycle.
- Throughput is one sample per cycle with `resultado_valido` held high. A run takes `N_AMOSTRAS` cycles of ACUMULANDO plus 1 cycle of start latency.

## Configuration
- Macro `ACUMULADOR_SATURA_EN`.
- Defined: on a carry-out, `total` clamps to all ones (2^LARGURA_ACC−1) and stays clamped for the rest of the run; `overflow` is set.
- Undefined: `total` wraps modulo 2^LARGURA_ACC; `overflow` is still set and sticky.

## Structure
- Shared package `acumulador_pkg` contains:
  - the state enumeration (OCIOSO, ACUMULANDO, CONCLUIDO);
  - `LARGURA_RESULTADO` = 5;
  - `MAX_RESULTADO` = 30.
- One natural sub-module, `contador_amostras`:
  - 8-bit counter with synchronous clear and enable, plus a terminal-count output compared against `N_AMOSTRAS`;
  - the FSM uses that output for the ACUMULANDO → CONCLUIDO transition.
- The bench instantiates `somador4bits` upstream and connects its `resultado` to this block's `resultado`.

## Test plan
- Reset mid-run: assert `rst_n`=0 after 2 of 4 transfers → all outputs 0 and state OCIOSO immediately; the next run behaves normally.
- Default parameters: pulse `iniciar`, then apply adder results 3+4, 15+15, 0+0, 9+1 back-to-back → `total`=47 and `contagem`=4 one cycle after the 4th transfer, `total_valido`=1, `overflow`=0, `pronto`=0.
- Gaps in `resultado_valido`: same four samples, each separated by 2 idle cycles → same `total`=47; `contagem` increments only on transfer cycles.
- Overflow, `N_AMOSTRAS`=10, ten samples of 30 (total 300):
  - with `ACUMULADOR_SATURA_EN` defined → `total`=255, `overflow`=1;
  - without it → `total`=44, `overflow`=1.
- Restart: `iniciar` after 2 transfers, with a valid sample in the same cycle → `total`=0 and `contagem`=0 next cycle, and that sample is not counted.

Source files
------------

// File: rtl/acumulador_pkg.sv
// acumulador_pkg
// Purpose: types and constants shared by the result accumulator and its
//          sample counter.
// Contents: run-state enumeration, adder result width and range, counter width.
package acumulador_pkg;

  localparam int unsigned LARGURA_RESULTADO = 5;
  localparam int unsigned MAX_RESULTADO     = 30;
  localparam int unsigned LARGURA_CONTAGEM  = 8;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ACUMULANDO = 2'd1,
    CONCLUIDO  = 2'd2
  } estado_t;

endpackage : acumulador_pkg

// File: rtl/acumulador_resultado_contador_amostras.sv
// contador_amostras
// Purpose: 8-bit count of samples accepted in the current run, with a
//          terminal flag telling the FSM that the next accepted sample
//          completes the run.
// Ports:
//   clk, rst_n     in  1  clock, async active-low reset
//   i_limpar       in  1  synchronous clear (has priority over enable)
//   i_habilitar    in  1  count one accepted sample
//   o_contagem     out 8  registered count
//   o_terminal_c   out 1  count equals N_AMOSTRAS-1 (combinational decode)
module contador_amostras
  import acumulador_pkg::*;
#(
  parameter int unsigned N_AMOSTRAS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_limpar,
  input  logic                        i_habilitar,
  output logic [LARGURA_CONTAGEM-1:0] o_contagem,
  output logic                        o_terminal_c
);

  logic [LARGURA_CONTAGEM-1:0] r_contagem;

  // Sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_contagem <= '0;
    end else if (i_limpar) begin
      r_contagem <= '0;
    end else if (i_habilitar) begin
      r_contagem <= r_contagem + LARGURA_CONTAGEM'(1);
    end
  end

  // Compared one below the target so the FSM can leave ACUMULANDO on the
  // same edge that registers the Nth sample.
  assign o_terminal_c = (r_contagem == LARGURA_CONTAGEM'(N_AMOSTRAS - 1));
  assign o_contagem   = r_contagem;

endmodule : contador_amostras

// File: rtl/somador4bits.sv
// somador4bits
// Purpose: purely combinational 4-bit unsigned adder that feeds the
//          accumulator on the practice board.
// Ports:
//   i_a, i_b       in  4  operands
//   o_resultado_c  out 5  a + b, range 0..30 (combinational)
module somador4bits
  import acumulador_pkg::*;
(
  input  logic [3:0]                   i_a,
  input  logic [3:0]                   i_b,
  output logic [LARGURA_RESULTADO-1:0] o_resultado_c
);

  assign o_resultado_c = LARGURA_RESULTADO'(i_a) + LARGURA_RESULTADO'(i_b);

endmodule : somador4bits

// File: rtl/acumulador_resultado.sv
// acumulador_resultado
// Purpose: accepts 5-bit adder results over a valid/ready handshake and sums
//          N_AMOSTRAS of them into a LARGURA_ACC-bit total, flagging a held
//          completion and a sticky overflow.
// Build option: ACUMULADOR_SATURA_EN -- when defined the total clamps to all
//          ones on carry-out; otherwise it wraps modulo 2^LARGURA_ACC.
// Ports:
//   clk, rst_n         in  1   clock, async active-low reset
//   iniciar            in  1   start/restart a run (clears total/count/overflow)
//   resultado_valido   in  1   upstream sample valid
//   resultado          in  5   adder result, 0..30
//   pronto             out 1   ready to accept a sample
//   total              out W   accumulated sum
//   total_valido       out 1   run complete, total final
//   overflow           out 1   sticky carry-out seen this run
//   contagem           out 8   samples accepted this run
module acumulador_resultado
  import acumulador_pkg::*;
#(
  parameter int unsigned N_AMOSTRAS  = 4,
  parameter int unsigned LARGURA_ACC = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iniciar,
  input  logic                         resultado_valido,
  input  logic [LARGURA_RESULTADO-1:0] resultado,
  output logic                         pronto,
  output logic [LARGURA_ACC-1:0]       total,
  output logic                         total_valido,
  output logic                         overflow,
  output logic [LARGURA_CONTAGEM-1:0]  contagem
);

  localparam int unsigned LARGURA_SOMA = LARGURA_ACC + 1;

  estado_t                   r_estado;
  estado_t                   w_estado_prox;
  logic                      r_pronto;
  logic                      r_total_valido;
  logic                      w_pronto_prox;
  logic                      w_total_valido_prox;
  logic [LARGURA_ACC-1:0]    r_total;
  logic [LARGURA_ACC-1:0]    w_total_prox;
  logic                      r_overflow;
  logic [LARGURA_SOMA-1:0]   w_soma;
  logic                      w_transferencia;
  logic                      w_terminal;

  // iniciar wins over a same-cycle transfer, which is then discarded
  assign w_transferencia = resultado_valido && r_pronto && !iniciar;

  contador_amostras #(
    .N_AMOSTRAS (N_AMOSTRAS)
  ) u_contador_amostras (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_limpar     (iniciar),
    .i_habilitar  (w_transferencia),
    .o_contagem   (contagem),
    .o_terminal_c (w_terminal)
  );

  // State register plus the registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado       <= OCIOSO;
      r_pronto       <= 1'b0;
      r_total_valido <= 1'b0;
    end else begin
      r_estado       <= w_estado_prox;
      r_pronto       <= w_pronto_prox;
      r_total_valido <= w_total_valido_prox;
    end
  end

  // Next state and next-state output decode
  always_comb begin
    w_estado_prox       = r_estado;
    w_pronto_prox       = 1'b0;
    w_total_valido_prox = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (iniciar) w_estado_prox = ACUMULANDO;
      end
      ACUMULANDO: begin
        if (iniciar)                              w_estado_prox = ACUMULANDO;
        else if (w_transferencia && w_terminal)   w_estado_prox = CONCLUIDO;
      end
      CONCLUIDO: begin
        if (iniciar) w_estado_prox = ACUMULANDO;
      end
      default: w_estado_prox = OCIOSO;
    endcase
    w_pronto_prox       = (w_estado_prox == ACUMULANDO);
    w_total_valido_prox = (w_estado_prox == CONCLUIDO);
  end

  // One extra bit so the carry-out is visible
  assign w_soma = LARGURA_SOMA'(r_total) + LARGURA_SOMA'(resultado);

`ifdef ACUMULADOR_SATURA_EN
  // Once clamped, the total stays at all ones for the rest of the run
  assign w_total_prox = (w_soma[LARGURA_ACC] || r_overflow) ? '1 : w_soma[LARGURA_ACC-1:0];
`else
  assign w_total_prox = w_soma[LARGURA_ACC-1:0];
`endif

  // Accumulator and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total    <= '0;
      r_overflow <= 1'b0;
    end else if (iniciar) begin
      r_total    <= '0;
      r_overflow <= 1'b0;
    end else if (w_transferencia) begin
      r_total <= w_total_prox;
      if (w_soma[LARGURA_ACC]) r_overflow <= 1'b1;
    end
  end

  assign pronto       = r_pronto;
  assign total        = r_total;
  assign total_valido = r_total_valido;
  assign overflow     = r_overflow;

endmodule : acumulador_resultado
